// File: rtl/nx_indirect_access_initiator.sv
// Host-side sequencer for an nx_*_indirect_access target: writes data then command,
// polls status out of BUSY, and returns a status/read-data response.
module nx_indirect_access_initiator #(
    parameter int unsigned N_REG_ADDR_BITS = 16,
    parameter int unsigned N_DATA_BITS     = 32,
    parameter int unsigned N_ENTRIES       = 1024,
    parameter int unsigned CMND_ADDRESS    = 0,
    parameter int unsigned DATA_ADDRESS    = 4,
    parameter int unsigned N_TIMEOUT_BITS  = 10,
    localparam int unsigned AW = (N_ENTRIES > 1) ? $clog2(N_ENTRIES) : 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [3:0]                 req_op,
    input  logic [AW-1:0]              req_addr,
    input  logic [N_DATA_BITS-1:0]     req_wdat,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [2:0]                 rsp_status,
    output logic [N_DATA_BITS-1:0]     rsp_rdat,
    output logic [N_REG_ADDR_BITS-1:0] reg_addr,
    output logic                       wr_stb,
    output logic [N_DATA_BITS-1:0]     wr_dat,
    output logic [3:0]                 cmnd_op,
    output logic [AW-1:0]              cmnd_addr,
    input  logic [2:0]                 stat_code,
    input  logic [N_DATA_BITS-1:0]     rd_dat
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_WDATA = 3'd1;
    localparam logic [2:0] ST_CMND  = 3'd2;
    localparam logic [2:0] ST_GUARD = 3'd3;
    localparam logic [2:0] ST_WAIT  = 3'd4;
    localparam logic [2:0] ST_RESP  = 3'd5;

    localparam logic [3:0] OP_NOP      = 4'd0;
    localparam logic [3:0] OP_READ     = 4'd1;
    localparam logic [3:0] OP_WRITE    = 4'd2;
    localparam logic [3:0] OP_INIT     = 4'd3;
    localparam logic [3:0] OP_INIT_INC = 4'd4;

    localparam logic [2:0] STAT_OK      = 3'd0;
    localparam logic [2:0] STAT_BUSY    = 3'd1;
    localparam logic [2:0] STAT_ILLEGAL = 3'd6;
    localparam logic [2:0] STAT_TIMEOUT = 3'd7;

    localparam logic [N_REG_ADDR_BITS-1:0] CMND_REG = N_REG_ADDR_BITS'(CMND_ADDRESS);
    localparam logic [N_REG_ADDR_BITS-1:0] DATA_REG = N_REG_ADDR_BITS'(DATA_ADDRESS);

    logic [2:0]                 state_q, state_d;
    logic [3:0]                 op_q, op_d;
    logic [AW-1:0]              addr_q, addr_d;
    logic [N_TIMEOUT_BITS-1:0]  timer_q, timer_d;
    logic [2:0]                 status_q, status_d;
    logic [N_DATA_BITS-1:0]     rdat_q, rdat_d;
    logic                       wr_stb_q, wr_stb_d;
    logic [N_REG_ADDR_BITS-1:0] reg_addr_q, reg_addr_d;
    logic [N_DATA_BITS-1:0]     wr_dat_q, wr_dat_d;
    logic [3:0]                 cmnd_op_q, cmnd_op_d;
    logic [AW-1:0]              cmnd_addr_q, cmnd_addr_d;

    logic                       cmnd_load;
    logic [3:0]                 cmnd_src_op;
    logic [AW-1:0]              cmnd_src_addr;
    logic [N_DATA_BITS-1:0]     cmnd_word;
    logic [N_TIMEOUT_BITS-1:0]  timer_inc;

    assign timer_inc = timer_q + 1'b1;

    always_comb begin
        cmnd_word                   = '0;
        cmnd_word[AW-1:0]           = cmnd_src_addr;
        cmnd_word[AW +: 4]          = cmnd_src_op;
    end

    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        addr_d        = addr_q;
        timer_d       = timer_q;
        status_d      = status_q;
        rdat_d        = rdat_q;
        wr_stb_d      = 1'b0;
        reg_addr_d    = reg_addr_q;
        wr_dat_d      = wr_dat_q;
        cmnd_op_d     = cmnd_op_q;
        cmnd_addr_d   = cmnd_addr_q;
        cmnd_load     = 1'b0;
        cmnd_src_op   = op_q;
        cmnd_src_addr = addr_q;

        // Strobe outputs are registered on entry so they are valid in WDATA/CMND itself.
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    op_d   = req_op;
                    addr_d = req_addr;
                    case (req_op)
                        OP_NOP: begin
                            status_d = STAT_OK;
                            rdat_d   = '0;
                            state_d  = ST_RESP;
                        end
                        OP_READ: begin
                            cmnd_load     = 1'b1;
                            cmnd_src_op   = req_op;
                            cmnd_src_addr = req_addr;
                            state_d       = ST_CMND;
                        end
                        OP_WRITE, OP_INIT, OP_INIT_INC: begin
                            wr_stb_d   = 1'b1;
                            reg_addr_d = DATA_REG;
                            wr_dat_d   = req_wdat;
                            state_d    = ST_WDATA;
                        end
                        default: begin
                            status_d = STAT_ILLEGAL;
                            rdat_d   = '0;
                            state_d  = ST_RESP;
                        end
                    endcase
                end
            end
            ST_WDATA: begin
                cmnd_load = 1'b1;
                state_d   = ST_CMND;
            end
            ST_CMND: begin
                timer_d = '0;
                state_d = ST_GUARD;
            end
            ST_GUARD: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                timer_d = timer_inc;
                if (stat_code != STAT_BUSY) begin
                    status_d = stat_code;
                    rdat_d   = (op_q == OP_READ && stat_code == STAT_OK) ? rd_dat : '0;
                    state_d  = ST_RESP;
                end else if (&timer_inc) begin
                    status_d = STAT_TIMEOUT;
                    rdat_d   = '0;
                    state_d  = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (cmnd_load) begin
            wr_stb_d    = 1'b1;
            reg_addr_d  = CMND_REG;
            cmnd_op_d   = cmnd_src_op;
            cmnd_addr_d = cmnd_src_addr;
            wr_dat_d    = cmnd_word;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            op_q        <= '0;
            addr_q      <= '0;
            timer_q     <= '0;
            status_q    <= '0;
            rdat_q      <= '0;
            wr_stb_q    <= 1'b0;
            reg_addr_q  <= '0;
            wr_dat_q    <= '0;
            cmnd_op_q   <= '0;
            cmnd_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            addr_q      <= addr_d;
            timer_q     <= timer_d;
            status_q    <= status_d;
            rdat_q      <= rdat_d;
            wr_stb_q    <= wr_stb_d;
            reg_addr_q  <= reg_addr_d;
            wr_dat_q    <= wr_dat_d;
            cmnd_op_q   <= cmnd_op_d;
            cmnd_addr_q <= cmnd_addr_d;
        end
    end

    assign req_ready  = (state_q == ST_IDLE);
    assign rsp_valid  = (state_q == ST_RESP);
    // Response fields are only loaded on entry to RESP, so they stay stable while stalled.
    assign rsp_status = (state_q == ST_RESP) ? status_q : '0;
    assign rsp_rdat   = (state_q == ST_RESP) ? rdat_q : '0;
    assign wr_stb     = wr_stb_q;
    assign reg_addr   = reg_addr_q;
    assign wr_dat     = wr_dat_q;
    assign cmnd_op    = cmnd_op_q;
    assign cmnd_addr  = cmnd_addr_q;

endmodule

// File: doc/nx_indirect_access_initiator.md
# nx_indirect_access_initiator

Host-side sequencer that drives the command/status register interface of an indirect-access memory wrapper (1RW RAM, 2P RAM, ROM or CAM controllers). It accepts one memory request at a time over a valid/ready handshake and issues the target register writes: the data word first, then the command. It polls the target status until it leaves BUSY, then captures read data and returns a status/data response over a second valid/ready channel. It sits between a CSR fabric master or test engine and one `nx_*_indirect_access` instance.

## Interface
- N_REG_ADDR_BITS, 16, width of target register address
- N_DATA_BITS, 32, width of data word
- N_ENTRIES, 1024, target entry count; address width is `LOG_VEC(N_ENTRIES)`
- CMND_ADDRESS, 0, register address of target command register
- DATA_ADDRESS, 4, register address of target data register
- N_TIMEOUT_BITS, 10, width of the poll timeout counter; timeout equals 2^N_TIMEOUT_BITS-1 cycles
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  host request valid
- req_ready  out  1  request accepted when valid&ready
- req_op  in  4  0 NOP, 1 READ, 2 WRITE, 3 INIT, 4 INIT_INC; other values illegal
- req_addr  in  LOG(N_ENTRIES)  entry address
- req_wdat  in  N_DATA_BITS  write data for WRITE, INIT and INIT_INC
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumed when valid&ready
- rsp_status  out  3  0 OK, 1 BUSY (never returned), 2–5 target error code passed through, 6 ILLEGAL_OP, 7 TIMEOUT
- rsp_rdat  out  N_DATA_BITS  captured read data; 0 unless op is READ with status OK
- reg_addr  out  N_REG_ADDR_BITS  target register address
- wr_stb  out  1  target register write strobe
- wr_dat  out  N_DATA_BITS  target register write data
- cmnd_op  out  4  command opcode
- cmnd_addr  out  LOG(N_ENTRIES)  command address
- stat_code  in  3  target status (1 = BUSY)
- rd_dat  in  N_DATA_BITS  target read data register

## Operation
- States: IDLE, WDATA, CMND, GUARD, WAIT, RESP.
- IDLE: req_ready=1. On handshake, latch op/addr/wdat.
  - op is illegal or NOP: go to RESP with status 6 for illegal, 0 for NOP. No target access.
  - op is WRITE, INIT or INIT_INC: go to WDATA.
  - op is READ: go to CMND.
- WDATA (1 cycle): wr_stb=1, reg_addr=DATA_ADDRESS, wr_dat=latched wdat. Go to CMND.
- CMND (1 cycle): wr_stb=1, reg_addr=CMND_ADDRESS, cmnd_op/cmnd_addr=latched values, wr_dat={cmnd_op,cmnd_addr} zero-extended. Clear timer. Go to GUARD.
- GUARD (1 cycle): ignores stat_code, because the target registers its status one cycle after the command. Go to WAIT.
- WAIT: timer increments each cycle.
  - stat_code≠1: latch status=stat_code. Latch rsp_rdat=rd_dat if op is READ and stat_code is 0, else 0. Go to RESP.
  - Timer reaches all-ones while stat_code=1: status=7, rdat=0. Go to RESP.
  - Status takes priority over timeout when both occur in the same cycle.
- RESP: rsp_valid=1 with held status/data. On rsp_ready, go to IDLE.
- Outside WDATA/CMND: wr_stb=0. reg_addr, cmnd_op and cmnd_addr hold their last driven values.
- Reset, including mid-operation: state=IDLE, req_ready=1, and all other outputs 0. An in-flight command is abandoned with no response.

## Timing
- req_ready is combinational from state only. It is not a function of req_valid.
- READ, target finishes in K cycles after GUARD: request accepted at cycle 0, CMND at 1, GUARD at 2, status seen at 3+K, rsp_valid at 4+K.
- WRITE adds one cycle for WDATA.
- NOP/illegal: rsp_valid the cycle after acceptance.
- Throughput: at most one outstanding request. The next request can be accepted the cycle after the response handshake.
- rsp_status and rsp_rdat are stable while rsp_valid=1 and rsp_ready=0.

## Test plan
- READ addr 0x3, target BUSY for 2 cycles then status 0 with rd_dat=0xDEADBEEF -> reg_addr=CMND_ADDRESS, cmnd_op=1, one wr_stb. Response status 0, rdat 0xDEADBEEF, 6 cycles after acceptance.
- WRITE addr 0x10, data 0x12345678, target status 0 immediately -> wr_stb at DATA_ADDRESS with 0x12345678, then at CMND_ADDRESS with op 2. Response status 0, rdat 0.
- req_op=9 -> no wr_stb. Response status 6 the next cycle.
- Target holds stat_code=1 forever with N_TIMEOUT_BITS=4 -> response status 7 after 15 WAIT cycles, rdat 0.
- rsp_ready held low for 5 cycles, with req_valid asserted throughout -> response held stable and req_ready=0 until the response handshake.
- Assert rst_n low during WAIT -> outputs 0 and req_ready=1 next cycle. The next READ completes normally.
